// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared widths and payload bundle for the EX/MEM stage
package ex_mem_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] alu_y;
    logic              zero;
    logic [DATA_W-1:0] wr_data;
    logic [REG_W-1:0]  dst_reg;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
  } ex_mem_bundle_t;

  localparam int BUNDLE_W = $bits(ex_mem_bundle_t);
endpackage

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - 2-slot valid/ready skid buffer with flush
// in_ready comes straight from a flop so upstream never sees a path from out_ready.
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept, drain;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid && !skid_valid_q;
  assign drain     = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full means in_ready is low, so only a refill of main can happen.
      if (drain) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end
endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with skid buffering and branch resolve
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  dst_reg,
  input  logic              ctl_reg_write,
  input  logic              ctl_mem_write,
  input  logic              ctl_mem_to_reg,
  input  logic              ctl_branch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] m_alu_y,
  output logic [DATA_W-1:0] m_wr_data,
  output logic [REG_W-1:0]  m_dst_reg,
  output logic              m_reg_write,
  output logic              m_mem_write,
  output logic              m_mem_to_reg,
  output logic              pc_src
);
  ex_mem_bundle_t in_bundle;
  ex_mem_bundle_t out_bundle;

  always_comb begin
    in_bundle            = '0;
    in_bundle.alu_y      = alu_y;
    in_bundle.zero       = alu_zero;
    in_bundle.wr_data    = wr_data;
    in_bundle.dst_reg    = dst_reg;
    in_bundle.reg_write  = ctl_reg_write;
    in_bundle.mem_write  = ctl_mem_write;
    in_bundle.mem_to_reg = ctl_mem_to_reg;
    in_bundle.branch     = ctl_branch;
  end

  pipe_skid_buffer #(
    .WIDTH(BUNDLE_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_bundle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_bundle)
  );

  assign m_alu_y      = out_bundle.alu_y;
  assign m_wr_data    = out_bundle.wr_data;
  assign m_dst_reg    = out_bundle.dst_reg;
  assign m_reg_write  = out_bundle.reg_write;
  assign m_mem_write  = out_bundle.mem_write;
  assign m_mem_to_reg = out_bundle.mem_to_reg;
  // Gated by out_valid so a stale flushed entry can never redirect the PC.
  assign pc_src       = out_bundle.branch && out_bundle.zero && out_valid;
endmodule
